serial_sub: RTL

- Bit-serial subtractor: computes diff = a - b - bin over WIDTH clock cycles, one full-subtractor bit slice per cycle, LSB first.
- Sits directly upstream of the combinational full-subtractor cell: it holds the operand shift registers and the borrow flip-flop, and feeds one (a, b, borrow-in) triple per cycle into that cell's logic.
- Start/done handshake toward the controlling logic. The result and final borrow are held until the next operation completes.

---
 rtl/serial_sub.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor, one full-subtractor slice per clock, LSB first
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             ai;
    logic             bi;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             load;
    logic             last;

    // Full-subtractor slice fed from the operand LSBs and the borrow flop.
    always_comb begin
        ai       = a_sr[0];
        bi       = b_sr[0];
        d        = ai ^ bi ^ br;
        br_next  = (~ai & bi) | (~(ai ^ bi) & br);
        res_next = {d, res_sr};
        load     = start && (state != S_SHIFT);
        last     = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SHIFT;
            S_SHIFT: if (last) state_next = S_DONE;
            S_DONE:  state_next = start ? S_SHIFT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SHIFT);
        done = (state == S_DONE);
    end

    // diff/borrow are only written on the final slice, so they hold across the next operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            br     <= bin;
        end else if (state == S_SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next[WIDTH-1:1];
            cnt    <= cnt + CW'(1);
            br     <= br_next;
            if (last) begin
                diff   <= res_next;
                borrow <= br_next;
            end
        end
    end

endmodule
